axi4lite_slave_mem: RTL and testbench
=====================================

// Module: axi4lite_slave_mem
// PURPOSE
//  Downstream end of the AXI4-Lite link: a slave with a small word-addressed register memory.
//  - Consumes the AW/W/B and AR/R channels driven by the AXI4-Lite master DUV, which
//    turns rd_en/wr_en + addresses/data into bus transactions.
//  - Performs byte-strobed writes and single-word reads.
//  - Returns OKAY for in-range accesses and SLVERR for out-of-range ones.
// PARAMETERS
//  ADDRWIDTH  32  byte-address width (matches axi4lite_pkg)
//  DATAWIDTH  32  data width; multiple of 8
//  DEPTH      16  number of DATAWIDTH words; in-range iff word index < DEPTH
// PORTS
//  clk      in   1            single clock, rising edge
//  rst      in   1            asynchronous, active-high reset
//  AWADDR   in   ADDRWIDTH    write byte address
//  AWVALID  in   1            write address valid
//  AWREADY  out  1            write address ready
//  WDATA    in   DATAWIDTH    write data
//  WSTRB    in   DATAWIDTH/8  byte enables
//  WVALID   in   1            write data valid
//  WREADY   out  1            write data ready
//  BRESP    out  2            write response (OKAY/SLVERR)
//  BVALID   out  1            write response valid
//  BREADY   in   1            master accepts response
//  ARADDR   in   ADDRWIDTH    read byte address
//  ARVALID  in   1            read address valid
//  ARREADY  out  1            read address ready
//  RDATA    out  DATAWIDTH    read data
//  RRESP    out  2            read response (OKAY/SLVERR)
//  RVALID   out  1            read data valid
//  RREADY   in   1            master accepts read data
// BEHAVIOUR
//  Reset (async, immediate):
//   - BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=OKAY.
//   - AWREADY=WREADY=ARREADY=1 from the first cycle after reset release.
//   - Memory cleared to 0; pending captured AW/W discarded.
//   - Reset mid-transaction drops BVALID/RVALID at once; no response is ever issued for it.
//  Addressing:
//   - word index = addr >> $clog2(DATAWIDTH/8); low offset bits ignored (no unaligned error).
//   - index >= DEPTH, or any nonzero upper bits beyond the index range -> SLVERR.
//  Write path (states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP):
//   - AW and W are accepted independently, in either order or the same cycle.
//   - AWREADY=1 in W_IDLE and W_HAVE_DATA; WREADY=1 in W_IDLE and W_HAVE_ADDR; both 0 in W_RESP.
//   - On the edge where the second of AW/W handshakes completes (or both together):
//     update the memory bytes with WSTRB[i]=1 when in range, load BRESP, enter W_RESP with
//     BVALID=1 on the next cycle.
//   - Out-of-range writes leave the memory unchanged.
//   - W_RESP: hold BVALID/BRESP stable until BREADY=1, then go to W_IDLE (BVALID=0 next cycle).
//   - WSTRB=0 in range: no byte changes, BRESP=OKAY.
//  Read path (states R_IDLE, R_DATA):
//   - ARREADY=1 only in R_IDLE.
//   - On the AR handshake, register RDATA=mem[index] (0 if out of range) and RRESP;
//     RVALID=1 next cycle.
//   - Hold RDATA/RRESP/RVALID stable until RREADY=1, then return to R_IDLE.
//   - Maximum throughput is one read per 2 cycles.
//  Simultaneous events:
//   - Read and write channels are fully independent and may both be active.
//   - A write commit and an AR handshake to the same word on the same edge: the read
//     returns pre-write data (read samples the old value).
//   - VALID must not depend on READY; the slave never waits for VALID before asserting READY.
// STRUCTURE
//  - axi4lite_pkg holds ADDRWIDTH, DATAWIDTH, and resp_t enum {OKAY=2'b00, EXOKAY=2'b01,
//    SLVERR=2'b10, DECERR=2'b11}, plus the wr_state_t and rd_state_t enums.
//  - Sub-module axi4lite_slave_wr_fsm: AW/W capture, ready generation, and B response.
//    Outputs a single-cycle commit strobe with index, data, and strobe.
//  - The memory array and read FSM live in the top module.
// TESTING
//  1. Reset: assert rst mid-clock -> BVALID/RVALID=0 immediately; after release,
//     AWREADY=WREADY=ARREADY=1 and a read of 0x4 returns 0x0000_0000/OKAY.
//  2. Write then read, AW and W same cycle: AWADDR=0x8, WDATA=0xDEADBEEF, WSTRB=4'hF
//     -> BVALID next cycle, BRESP=OKAY; read 0x8 -> RDATA=0xDEADBEEF, RRESP=OKAY.
//  3. W before AW by 3 cycles, WSTRB=4'b0101, WDATA=0x11223344 over 0xDEADBEEF at 0x8
//     -> WREADY=0 while waiting; readback is 0xDE22BE44.
//  4. Out of range: write 0x40 (DEPTH=16) -> BRESP=SLVERR, memory unchanged;
//     read 0x40 -> RDATA=0, RRESP=SLVERR.
//  5. Backpressure: BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0;
//     RREADY=0 likewise holds RDATA and ARREADY=0.
//  6. Same-edge collision: write 0x0=0xA5A5A5A5 commits on the AR(0x0) edge; prior value
//     0x0 -> read returns 0x0; a second read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: bus widths, response codes and the
// slave's write/read FSM state encodings.
package axi4lite_pkg;

   localparam int ADDRWIDTH = 32;
   localparam int DATAWIDTH = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_ADDR,
      W_HAVE_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/axi4lite_slave_wr_fsm.sv
// Write-side control of the AXI4-Lite slave memory.
// Captures AW and W independently (either order or together), drives
// AWREADY/WREADY, issues a one-cycle in-range commit strobe carrying
// word index, data and byte strobe, and holds the B response until
// the master takes it.
// Ports: clk, rst (async, active-high); aw_addr/aw_valid/aw_ready;
// w_data/w_strb/w_valid/w_ready; b_resp/b_valid/b_ready;
// commit, commit_idx, commit_data, commit_strb to the memory array.
module axi4lite_slave_wr_fsm
   import axi4lite_pkg::*;
#(
   parameter int AW    = ADDRWIDTH,
   parameter int DW    = DATAWIDTH,
   parameter int DEPTH = 16,
   parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   aw_addr,
   input  logic            aw_valid,
   output logic            aw_ready,
   input  logic [DW-1:0]   w_data,
   input  logic [DW/8-1:0] w_strb,
   input  logic            w_valid,
   output logic            w_ready,
   output logic [1:0]      b_resp,
   output logic            b_valid,
   input  logic            b_ready,
   output logic            commit,
   output logic [IW-1:0]   commit_idx,
   output logic [DW-1:0]   commit_data,
   output logic [DW/8-1:0] commit_strb
);

   localparam int OFF = $clog2(DW / 8);

   wr_state_t       state;
   wr_state_t       state_nx;
   resp_t           resp_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic [DW/8-1:0] strb_q;

   logic            aw_hs;
   logic            w_hs;
   logic            done;
   logic            in_range;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic [DW/8-1:0] sel_strb;

   // Readies depend only on state, never on VALID.
   assign aw_ready = ~rst &
      ((state == W_IDLE) | (state == W_HAVE_DATA));
   assign w_ready  = ~rst &
      ((state == W_IDLE) | (state == W_HAVE_ADDR));
   assign aw_hs    = aw_valid & aw_ready;
   assign w_hs     = w_valid & w_ready;

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      sel_addr = addr_q;
      sel_data = data_q;
      sel_strb = strb_q;
      unique case (state)
         W_IDLE: begin
            sel_addr = aw_addr;
            sel_data = w_data;
            sel_strb = w_strb;
            if (aw_hs && w_hs) begin
               done     = 1'b1;
               state_nx = W_RESP;
            end else if (aw_hs) begin
               state_nx = W_HAVE_ADDR;
            end else if (w_hs) begin
               state_nx = W_HAVE_DATA;
            end
         end
         W_HAVE_ADDR: begin
            sel_data = w_data;
            sel_strb = w_strb;
            if (w_hs) begin
               done     = 1'b1;
               state_nx = W_RESP;
            end
         end
         W_HAVE_DATA: begin
            sel_addr = aw_addr;
            if (aw_hs) begin
               done     = 1'b1;
               state_nx = W_RESP;
            end
         end
         W_RESP: begin
            if (b_ready) state_nx = W_IDLE;
         end
         default: state_nx = W_IDLE;
      endcase
   end

   // Any set bit above the index field lands at or past DEPTH.
   assign in_range    = (sel_addr >> OFF) < AW'(DEPTH);
   assign commit      = done & in_range;
   assign commit_idx  = sel_addr[OFF +: IW];
   assign commit_data = sel_data;
   assign commit_strb = sel_strb;

   assign b_valid = (state == W_RESP);
   assign b_resp  = resp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= W_IDLE;
         resp_q <= OKAY;
         addr_q <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else begin
         state <= state_nx;
         if (aw_hs) addr_q <= aw_addr;
         if (w_hs) begin
            data_q <= w_data;
            strb_q <= w_strb;
         end
         if (done) resp_q <= in_range ? OKAY : SLVERR;
      end
   end

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave with a small word-addressed register memory.
// Byte-strobed writes, single-word reads, OKAY in range, SLVERR out.
// Ports: clk, rst (async, active-high); AW channel AWADDR/AWVALID/
// AWREADY; W channel WDATA/WSTRB/WVALID/WREADY; B channel BRESP/
// BVALID/BREADY; AR channel ARADDR/ARVALID/ARREADY; R channel
// RDATA/RRESP/RVALID/RREADY.
module axi4lite_slave_mem
   import axi4lite_pkg::*;
#(
   parameter int ADDRW = ADDRWIDTH,
   parameter int DATAW = DATAWIDTH,
   parameter int DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDRW-1:0]   AWADDR,
   input  logic               AWVALID,
   output logic               AWREADY,
   input  logic [DATAW-1:0]   WDATA,
   input  logic [DATAW/8-1:0] WSTRB,
   input  logic               WVALID,
   output logic               WREADY,
   output logic [1:0]         BRESP,
   output logic               BVALID,
   input  logic               BREADY,
   input  logic [ADDRW-1:0]   ARADDR,
   input  logic               ARVALID,
   output logic               ARREADY,
   output logic [DATAW-1:0]   RDATA,
   output logic [1:0]         RRESP,
   output logic               RVALID,
   input  logic               RREADY
);

   localparam int SW  = DATAW / 8;
   localparam int OFF = $clog2(SW);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATAW-1:0] mem [DEPTH];

   logic             commit;
   logic [IW-1:0]    commit_idx;
   logic [DATAW-1:0] commit_data;
   logic [SW-1:0]    commit_strb;

   axi4lite_slave_wr_fsm #(
      .AW    (ADDRW),
      .DW    (DATAW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_wr (
      .clk         (clk),
      .rst         (rst),
      .aw_addr     (AWADDR),
      .aw_valid    (AWVALID),
      .aw_ready    (AWREADY),
      .w_data      (WDATA),
      .w_strb      (WSTRB),
      .w_valid     (WVALID),
      .w_ready     (WREADY),
      .b_resp      (BRESP),
      .b_valid     (BVALID),
      .b_ready     (BREADY),
      .commit      (commit),
      .commit_idx  (commit_idx),
      .commit_data (commit_data),
      .commit_strb (commit_strb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (commit) begin
         for (int b = 0; b < SW; b++) begin
            if (commit_strb[b])
               mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
         end
      end
   end

   rd_state_t     rstate;
   rd_state_t     rstate_nx;
   logic          ar_hs;
   logic          ar_ok;
   logic [IW-1:0] ar_idx;

   assign ARREADY = ~rst & (rstate == R_IDLE);
   assign RVALID  = (rstate == R_DATA);
   assign ar_hs   = ARVALID & ARREADY;
   assign ar_ok   = (ARADDR >> OFF) < ADDRW'(DEPTH);
   assign ar_idx  = ARADDR[OFF +: IW];

   always_comb begin
      rstate_nx = rstate;
      unique case (rstate)
         R_IDLE:  if (ar_hs) rstate_nx = R_DATA;
         R_DATA:  if (RREADY) rstate_nx = R_IDLE;
         default: rstate_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rstate <= R_IDLE;
      else     rstate <= rstate_nx;
   end

   // Sampled with the pre-edge memory, so a same-edge commit is not seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RDATA <= '0;
         RRESP <= OKAY;
      end else if (ar_hs) begin
         RDATA <= ar_ok ? mem[ar_idx] : '0;
         RRESP <= ar_ok ? OKAY : SLVERR;
      end
   end

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Self-checking bench for axi4lite_slave_mem: directed table,
// hand-written corner sequences, and randomized traffic vs a model.
module tb_axi4lite_slave_mem;
   import axi4lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   always #5 clk = ~clk;

   axi4lite_slave_mem dut (
      .clk     (clk),
      .rst     (rst),
      .AWADDR  (AWADDR),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BRESP   (BRESP),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .ARADDR  (ARADDR),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .RVALID  (RVALID),
      .RREADY  (RREADY)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] model [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timed out", nm);
   endtask

   function automatic bit m_in_range(input logic [31:0] a);
      return (a / 4) < 16;
   endfunction

   function automatic logic [1:0] m_write(input logic [31:0] a,
      input logic [31:0] d, input logic [3:0] s);
      int idx;
      if (!m_in_range(a)) return 2'b10;
      idx = int'(a / 4);
      for (int b = 0; b < 4; b++)
         if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [1:0] m_read(input logic [31:0] a,
      output logic [31:0] d);
      if (!m_in_range(a)) begin
         d = 32'h0;
         return 2'b10;
      end
      d = model[int'(a / 4)];
      return 2'b00;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d,
      input logic [3:0] s, input int awd, input int wd,
      input int hold, output logic [1:0] resp);
      int cyc = 0;
      bit ad = 0, wdn = 0, fa, fw;
      logic [1:0] r0;
      AWADDR = a;
      WDATA  = d;
      WSTRB  = s;
      while (!(ad && wdn)) begin
         AWVALID = !ad && (cyc >= awd);
         WVALID  = !wdn && (cyc >= wd);
         if (wdn && !ad) chk("wready_wait", WREADY, 0);
         if (ad && !wdn) chk("awready_wait", AWREADY, 0);
         fa = AWVALID && AWREADY;
         fw = WVALID && WREADY;
         @(posedge clk); #1;
         ad  = ad | fa;
         wdn = wdn | fw;
         cyc++;
         if (cyc > 40) begin
            timeout("wr_handshake");
            break;
         end
      end
      AWVALID = 0;
      WVALID  = 0;
      chk("bvalid_latency", BVALID, 1);
      resp = BRESP;
      r0   = BRESP;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("bvalid_hold", BVALID, 1);
         chk("bresp_hold", BRESP, r0);
         chk("awready_in_resp", AWREADY, 0);
         chk("wready_in_resp", WREADY, 0);
      end
      BREADY = 1;
      @(posedge clk); #1;
      BREADY = 0;
      chk("bvalid_clear", BVALID, 0);
   endtask

   task automatic rd(input logic [31:0] a, input int hold,
      output logic [31:0] d, output logic [1:0] resp);
      int cyc = 0;
      bit fa;
      logic [31:0] d0;
      logic [1:0]  r0;
      ARADDR  = a;
      ARVALID = 1;
      forever begin
         fa = ARREADY;
         @(posedge clk); #1;
         cyc++;
         if (fa) break;
         if (cyc > 40) begin
            timeout("ar_handshake");
            break;
         end
      end
      ARVALID = 0;
      chk("rvalid_latency", RVALID, 1);
      d  = RDATA;
      resp = RRESP;
      d0 = RDATA;
      r0 = RRESP;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("rvalid_hold", RVALID, 1);
         chk("rdata_hold", RDATA, d0);
         chk("rresp_hold", RRESP, r0);
         chk("arready_in_data", ARREADY, 0);
      end
      RREADY = 1;
      @(posedge clk); #1;
      RREADY = 0;
      chk("rvalid_clear", RVALID, 0);
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, ed;
      logic [1:0]  r, er;

      tbl[0]  = '{1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
      tbl[1]  = '{0, 32'h08, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
      tbl[2]  = '{1, 32'h3C, 32'h12345678, 4'hF, 32'h0, 2'b00};
      tbl[3]  = '{0, 32'h3E, 32'h0, 4'h0, 32'h12345678, 2'b00};
      tbl[4]  = '{1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10};
      tbl[5]  = '{0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b10};
      tbl[6]  = '{0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[7]  = '{1, 32'h10, 32'h55555555, 4'h0, 32'h0, 2'b00};
      tbl[8]  = '{0, 32'h10, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[9]  = '{1, 32'h12, 32'hAABBCCDD, 4'h8, 32'h0, 2'b00};
      tbl[10] = '{0, 32'h10, 32'h0, 4'h0, 32'hAA000000, 2'b00};
      tbl[11] = '{0, 32'h80000008, 32'h0, 4'h0, 32'h0, 2'b10};
      tbl[12] = '{1, 32'h00010004, 32'h1, 4'hF, 32'h0, 2'b10};
      tbl[13] = '{0, 32'h04, 32'h0, 4'h0, 32'h0, 2'b00};

      rst = 1;
      AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
      BREADY = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;
      m_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;

      chk("rst_awready", AWREADY, 1);
      chk("rst_wready", WREADY, 1);
      chk("rst_arready", ARREADY, 1);
      chk("rst_bvalid", BVALID, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_bresp", BRESP, 0);
      chk("rst_rresp", RRESP, 0);

      wr(32'h4, 32'hCAFEF00D, 4'hF, 0, 0, 0, r);
      chk("pre_rst_bresp", r, 0);

      // Leave both responses pending, then reset mid-cycle.
      AWADDR = 32'h4; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
      ARADDR = 32'h4;
      AWVALID = 1; WVALID = 1; ARVALID = 1;
      @(posedge clk); #1;
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      chk("pend_bvalid", BVALID, 1);
      chk("pend_rvalid", RVALID, 1);
      chk("pend_rdata", RDATA, 32'hCAFEF00D);
      @(negedge clk);
      rst = 1;
      #1;
      chk("midrst_bvalid", BVALID, 0);
      chk("midrst_rvalid", RVALID, 0);
      chk("midrst_rdata", RDATA, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      m_clear();
      repeat (3) begin
         @(posedge clk); #1;
         chk("post_rst_no_b", BVALID, 0);
         chk("post_rst_no_r", RVALID, 0);
      end
      chk("post_rst_awready", AWREADY, 1);
      chk("post_rst_wready", WREADY, 1);
      chk("post_rst_arready", ARREADY, 1);
      rd(32'h4, 0, d, r);
      chk("rst_read4_data", d, 0);
      chk("rst_read4_resp", r, 0);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].is_wr) begin
            er = m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            wr(tbl[i].addr, tbl[i].data, tbl[i].strb,
               i % 2, (i / 2) % 3, i % 2, r);
            chk($sformatf("tbl%0d_bresp", i), r, tbl[i].exp_resp);
         end else begin
            rd(tbl[i].addr, i % 3, d, r);
            chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
            chk($sformatf("tbl%0d_rresp", i), r, tbl[i].exp_resp);
         end
      end

      // W leads AW by three cycles.
      er = m_write(32'h8, 32'h11223344, 4'b0101);
      wr(32'h8, 32'h11223344, 4'b0101, 3, 0, 0, r);
      chk("wfirst_bresp", r, 0);
      rd(32'h8, 0, d, r);
      chk("wfirst_rdata", d, 32'hDE22BE44);

      // Backpressure on both response channels.
      er = m_write(32'h14, 32'h0F0F0F0F, 4'hF);
      wr(32'h14, 32'h0F0F0F0F, 4'hF, 0, 0, 5, r);
      chk("bp_bresp", r, 0);
      rd(32'h14, 5, d, r);
      chk("bp_rdata", d, 32'h0F0F0F0F);

      // Write commit and AR handshake on the same edge.
      AWADDR = 32'h0; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
      ARADDR = 32'h0;
      AWVALID = 1; WVALID = 1; ARVALID = 1;
      @(posedge clk); #1;
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      chk("coll_bvalid", BVALID, 1);
      chk("coll_rvalid", RVALID, 1);
      chk("coll_rdata_old", RDATA, 0);
      chk("coll_rresp", RRESP, 0);
      BREADY = 1; RREADY = 1;
      @(posedge clk); #1;
      BREADY = 0; RREADY = 0;
      chk("coll_bclear", BVALID, 0);
      chk("coll_rclear", RVALID, 0);
      er = m_write(32'h0, 32'hA5A5A5A5, 4'hF);
      rd(32'h0, 0, d, r);
      chk("coll_rdata_new", d, 32'hA5A5A5A5);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, wd;
         logic [3:0]  s;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 8)       a = $urandom_range(0, 63);
         else if (sel == 8) a = $urandom_range(64, 255);
         else               a = $urandom | 32'h10000000;
         wd = $urandom;
         s  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            er = m_write(a, wd, s);
            wr(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), r);
            chk($sformatf("rnd%0d_bresp@%h", n, a), r, er);
         end else begin
            er = m_read(a, ed);
            rd(a, $urandom_range(0, 2), d, r);
            chk($sformatf("rnd%0d_rdata@%h", n, a), d, ed);
            chk($sformatf("rnd%0d_rresp@%h", n, a), r, er);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
